// File: rtl/periph_uart_tx.sv
// periph_uart_tx: serialises a watched 2*DATA_WIDTH-bit peripheral word as two UART bytes (low byte first) when it changes.
// Latency: a frame starts on the first edge where the word differs from the last one sent; tx is decoded from registered state.
// Backpressure: none. Changes to the word during a frame are ignored; only the value present after the frame is compared next.
//
// Ports:
//   clk              - single clock, all state updates on its rising edge
//   rst              - synchronous, active-high reset
//   PeripheralBuffer - watched word (memory bytes 0xFFFF:0xFFFE)
//   tx               - serial line, idle high
//   busy             - high while a two-byte frame is in progress
//   frame_done       - one-cycle pulse after the final stop bit of a frame
//
// Optional feature: define PERIPH_TX_PARITY_EN to add an even-parity bit after each data byte.
module periph_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] PeripheralBuffer,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PERIPH_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              byte_sel_q, byte_sel_d;
  logic [WW-1:0]     shift_word_q, shift_word_d;
  logic [WW-1:0]     last_sent_q, last_sent_d;
  logic              frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0] cur_byte;
  logic                  bit_end;

  // byte_sel picks the half of the captured word currently on the wire.
  assign cur_byte = byte_sel_q ? shift_word_q[WW-1:DATA_WIDTH] : shift_word_q[DATA_WIDTH-1:0];
  assign bit_end  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      byte_sel_q   <= 1'b0;
      shift_word_q <= '0;
      last_sent_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      byte_sel_q   <= byte_sel_d;
      shift_word_q <= shift_word_d;
      last_sent_q  <= last_sent_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    byte_sel_d   = byte_sel_q;
    shift_word_d = shift_word_q;
    last_sent_d  = last_sent_q;
    frame_done_d = 1'b0;
    tx           = 1'b1;
    busy         = 1'b1;

    // The bit timer free-runs through every non-idle state and wraps at the end of each bit.
    if (state_q == S_IDLE || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // Compare against the live word: anything that changed and changed back during a frame is dropped.
        if (PeripheralBuffer != last_sent_q) begin
          shift_word_d = PeripheralBuffer;
          byte_sel_d   = 1'b0;
          bit_d        = '0;
          state_d      = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx = cur_byte[bit_q];
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef PERIPH_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef PERIPH_TX_PARITY_EN
      S_PARITY: begin
        tx = ^cur_byte;
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = S_START;
          end else begin
            // Returning to idle here guarantees at least one idle cycle between frames.
            last_sent_d  = shift_word_q;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign frame_done = frame_done_q;

endmodule

// File: doc/periph_uart_tx.md
PERIPH_UART_TX -- requirements
Module: periph_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 8: serial byte width; the watched word SHALL be DATA_WIDTH*2 bits.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port PeripheralBuffer  input  DATA_WIDTH*2: the peripheral word at memory bytes 0xFFFF:0xFFFE, driven by the RAM block.
REQ-006 Port tx  output  1: serial line, idle high.
REQ-007 Port busy  output  1: high while a two-byte frame is in progress.
REQ-008 Port frame_done  output  1: single-cycle pulse when the final stop bit of a frame completes.

Function
REQ-009 The block SHALL hold a last_sent register, DATA_WIDTH*2 bits, that stores the last word it transmitted.
REQ-010 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP; a byte_sel flag SHALL select the byte, low byte first.
REQ-011 In IDLE, when PeripheralBuffer != last_sent, the block SHALL on that edge:
  - capture PeripheralBuffer into shift_word;
  - clear byte_sel;
  - enter START with tx=0 and busy=1.
REQ-012 In IDLE, when PeripheralBuffer == last_sent, the block SHALL stay in IDLE with tx=1 and busy=0.
REQ-013 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that counts 0..CLKS_PER_BIT-1 and wraps.
REQ-014 DATA SHALL shift out DATA_WIDTH bits of the selected byte, LSB first.
REQ-015 STOP SHALL drive tx=1.
REQ-016 At the end of STOP with byte_sel=0, the block SHALL set byte_sel=1 and re-enter START for the high byte.
REQ-017 At the end of STOP with byte_sel=1, the block SHALL on that edge:
  - load last_sent with the captured word;
  - pulse frame_done;
  - return to IDLE.
REQ-018 Changes on PeripheralBuffer during a frame SHALL NOT alter the frame in progress.
REQ-019 After a frame, the next comparison SHALL use the current PeripheralBuffer, so only the latest value is sent; intermediate values are dropped.
REQ-020 Between frames, tx SHALL stay 1 and busy SHALL stay 0 for at least one cycle.
REQ-021 Frame length without the macro SHALL be 2*(DATA_WIDTH+2)*CLKS_PER_BIT cycles, with busy high for that whole span.

Reset
REQ-022 While rst=1 the block SHALL force: state IDLE, tx=1, busy=0, frame_done=0, last_sent=0, bit counter=0, byte_sel=0.
REQ-023 A reset asserted mid-frame SHALL abort the frame on that edge; tx=1 SHALL be driven on the next cycle and no frame_done SHALL be issued.
REQ-024 After reset release, a nonzero PeripheralBuffer SHALL start a frame on the first non-reset edge.

Configuration
REQ-025 With PERIPH_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and transmit the even-parity bit (XOR of the byte bits).
REQ-026 With PERIPH_TX_PARITY_EN defined, frame length SHALL be 2*(DATA_WIDTH+3)*CLKS_PER_BIT cycles.
REQ-027 Without PERIPH_TX_PARITY_EN, the PARITY state and the parity logic SHALL be absent.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-028 Reset, then hold PeripheralBuffer=0x0000 for 200 cycles -> tx=1, busy=0 and no frame_done throughout.
REQ-029 Set PeripheralBuffer=0xAAAA -> each byte sent as tx 0,0,1,0,1,0,1,0,1,1 (4 cycles per bit); busy high for 80 cycles; one frame_done pulse; then idle.
REQ-030 Set 0x1234; during that frame apply 0x1111 then 0x5678 -> 0x34,0x12 sent; then after 1 or more idle cycles 0x78,0x56 sent; 0x1111 never sent.
REQ-031 Assert rst for 1 cycle in the DATA state of the low byte of 0xBEEF -> tx=1 next cycle, no frame_done; then a fresh full frame 0xEF,0xBE.
REQ-032 Define PERIPH_TX_PARITY_EN and send 0x0301 -> parity bit 1 for byte 0x01 and 0 for byte 0x03; busy high for 88 cycles.
